// File: rtl/io_packet_decoder_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the controller
// packet decoder.
package io_packet_decoder_pkg;

    localparam logic [7:0]  HEADER_DEFAULT  = 8'hA5;
    localparam int unsigned TIMEOUT_DEFAULT = 50000;
    localparam int unsigned STALE_DEFAULT   = 5000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_LO  = 2'd1,
        GET_HI  = 2'd2,
        GET_CHK = 2'd3
    } state_t;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] lo,
                                                input logic [7:0] hi,
                                                input logic [7:0] header);
        return lo ^ hi ^ header;
    endfunction

endpackage

// File: rtl/io_packet_decoder_timeout_counter.sv
// Saturating cycle counter; expired rises when LIMIT cycles of enable have
// elapsed since the last clear and stays high until the next clear.
module timeout_counter #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W       = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count < LIMIT_W)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_W);

endmodule

// File: rtl/io_packet_decoder.sv
// Assembles HEADER,LO,HI,CHK packets from the UART byte stream, holds the last
// good button state and tracks link health and error count.
module io_packet_decoder
    import io_packet_decoder_pkg::*;
#(
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned STALE_CYCLES   = STALE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] buttons,
    output logic [7:0]  io_data,
    output logic        packet_valid,
    output logic        link_up,
    output logic [7:0]  error_count
);

    state_t     state, next_state;
    logic [7:0] lo, hi;
    logic       accept, bad_chk, timeout;
    logic       byte_expired, stale_expired;

    timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_byte_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (rx_valid || (state == IDLE)),
        .enable  (state != IDLE),
        .expired (byte_expired)
    );

    timeout_counter #(.LIMIT(STALE_CYCLES)) u_stale_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (1'b1),
        .expired (stale_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A received byte always takes precedence over an expiring inter-byte timer.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        bad_chk    = 1'b0;
        timeout    = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE:    if (rx_data == HEADER) next_state = GET_LO;
                GET_LO:  next_state = GET_HI;
                GET_HI:  next_state = GET_CHK;
                GET_CHK: begin
                    next_state = IDLE;
                    if (rx_data == pkt_checksum(lo, hi, HEADER)) accept  = 1'b1;
                    else                                         bad_chk = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end else if ((state != IDLE) && byte_expired) begin
            next_state = IDLE;
            timeout    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo           <= '0;
            hi           <= '0;
            buttons      <= '0;
            packet_valid <= 1'b0;
            link_up      <= 1'b0;
            error_count  <= '0;
        end else begin
            if (rx_valid && (state == GET_LO)) lo <= rx_data;
            if (rx_valid && (state == GET_HI)) hi <= rx_data;

            packet_valid <= accept;

            // Stale link blanks the inputs so the game sees no buttons held.
            if (accept) begin
                buttons <= {hi, lo};
                link_up <= 1'b1;
            end else if (stale_expired) begin
                buttons <= '0;
                link_up <= 1'b0;
            end

            if ((bad_chk || timeout) && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

    assign io_data = buttons[7:0];

endmodule

// File: tb/tb_io_packet_decoder.sv
// Directed scoreboard bench for io_packet_decoder with short timer limits.
module tb_io_packet_decoder;

    localparam int unsigned TIMEOUT_CYCLES = 20;
    localparam int unsigned STALE_CYCLES   = 100;

    logic        clock;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] buttons;
    logic [7:0]  io_data;
    logic        packet_valid;
    logic        link_up;
    logic [7:0]  error_count;

    typedef struct {
        logic [15:0] btn;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    logic        prev_pv  = 1'b0;

    io_packet_decoder #(
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STALE_CYCLES   (STALE_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .buttons      (buttons),
        .io_data      (io_data),
        .packet_valid (packet_valid),
        .link_up      (link_up),
        .error_count  (error_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every packet_valid pulse must match the oldest expected packet.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && packet_valid) begin
            check("pv_width", {31'd0, prev_pv}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pv", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pv_buttons", {16'd0, buttons}, {16'd0, e.btn});
                check("pv_io_data", {24'd0, io_data}, {24'd0, e.btn[7:0]});
                check("pv_link_up", {31'd0, link_up}, 32'd1);
                check("pv_latency", cyc, e.cyc);
            end
        end
        prev_pv = packet_valid;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] chk, input bit good);
        exp_t e;
        send_byte(8'hA5);
        send_byte(lo);
        send_byte(hi);
        send_byte(chk);
        if (good) begin
            e.btn = {hi, lo};
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_buttons", {16'd0, buttons}, 32'h0);
        check("rst_io_data", {24'd0, io_data}, 32'h0);
        check("rst_pv", {31'd0, packet_valid}, 32'h0);
        check("rst_link", {31'd0, link_up}, 32'h0);
        check("rst_err", {24'd0, error_count}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Good packet
        send_pkt(8'h34, 8'h12, 8'h83, 1'b1);
        idle(2);
        check("good_buttons", {16'd0, buttons}, 32'h1234);
        check("good_io", {24'd0, io_data}, 32'h34);
        check("good_link", {31'd0, link_up}, 32'h1);
        check("good_err", {24'd0, error_count}, 32'h0);

        // Bad checksum, then recovery
        send_pkt(8'h34, 8'h12, 8'h00, 1'b0);
        idle(2);
        check("bad_buttons", {16'd0, buttons}, 32'h1234);
        check("bad_err", {24'd0, error_count}, 32'h1);
        send_pkt(8'hFF, 8'h00, 8'h5A, 1'b1);
        idle(2);
        check("rec_buttons", {16'd0, buttons}, 32'h00FF);

        // Inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h34);
        idle(25);
        check("to_err", {24'd0, error_count}, 32'h2);
        send_byte(8'h12);
        send_byte(8'h83);
        send_pkt(8'h01, 8'h02, 8'hA6, 1'b1);
        idle(2);
        check("to_buttons", {16'd0, buttons}, 32'h0201);
        check("to_err_after", {24'd0, error_count}, 32'h2);

        // Junk before header, header value inside data
        send_byte(8'h00);
        send_byte(8'h7F);
        send_pkt(8'hA5, 8'hA5, 8'hA5, 1'b1);
        idle(2);
        check("junk_buttons", {16'd0, buttons}, 32'hA5A5);
        check("junk_err", {24'd0, error_count}, 32'h2);

        // Stale link
        send_pkt(8'hF0, 8'h00, 8'h55, 1'b1);
        idle(2);
        check("pre_stale_link", {31'd0, link_up}, 32'h1);
        idle(110);
        check("stale_link", {31'd0, link_up}, 32'h0);
        check("stale_buttons", {16'd0, buttons}, 32'h0);
        check("stale_io", {24'd0, io_data}, 32'h0);
        send_pkt(8'h34, 8'h12, 8'h83, 1'b1);
        idle(2);
        check("relink_link", {31'd0, link_up}, 32'h1);
        check("relink_buttons", {16'd0, buttons}, 32'h1234);

        // Error count saturation
        for (int i = 0; i < 300; i++) send_pkt(8'h34, 8'h12, 8'h00, 1'b0);
        idle(2);
        check("sat_err", {24'd0, error_count}, 32'hFF);

        // Reset mid-packet
        send_pkt(8'h34, 8'h12, 8'h83, 1'b1);
        idle(2);
        send_byte(8'hA5);
        send_byte(8'h34);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("mrst_buttons", {16'd0, buttons}, 32'h0);
        check("mrst_io", {24'd0, io_data}, 32'h0);
        check("mrst_link", {31'd0, link_up}, 32'h0);
        check("mrst_err", {24'd0, error_count}, 32'h0);
        check("mrst_pv", {31'd0, packet_valid}, 32'h0);
        send_pkt(8'h78, 8'h56, 8'h8B, 1'b1);
        idle(2);
        check("post_rst_buttons", {16'd0, buttons}, 32'h5678);
        check("post_rst_err", {24'd0, error_count}, 32'h0);

        idle(4);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
